ysyx_22050133_mdu_ctrl: RTL and testbench

Iterative multiply/divide unit and its sequencer for the RV64 core. It sits beside the EX-stage ALU and takes over every M-extension ALUop (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU and their W forms). It runs a shift-add multiplier or a restoring divider over many cycles and asserts `busy` so the pipeline stalls until the result is consumed.

---
 rtl/ysyx_22050133_mdu_pkg.sv | 37 +++
 rtl/ysyx_22050133_mdu_prep.sv | 86 ++++++++
 rtl/ysyx_22050133_mdu_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_ysyx_22050133_mdu_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050133_mdu_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
// Contents: ALUop codes for the M set, the sequencer state enum,
// iteration counts, special-case constants and a W-result formatter.
// Optional feature macro used by the unit: MDU_FAST_MUL_EN.
package ysyx_22050133_mdu_pkg;

  localparam int XLEN = 64;

  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MUL,
    S_DIV,
    S_DONE
  } mdu_state_e;

  localparam logic [6:0]      ITER_W     = 7'd32;
  localparam logic [6:0]      ITER_D     = 7'd64;
  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [31:0]     MIN_S32    = 32'h8000_0000;
  localparam logic [63:0]     MIN_S64    = 64'h8000_0000_0000_0000;

  // W results are the sign-extended low word; full-width results pass through.
  function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] v, input logic w);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

endpackage

// File: rtl/ysyx_22050133_mdu_prep.sv
// Combinational operand preparation for the multiply/divide unit.
// Ports:
//   op, word       latched ALUop and W flag
//   src1, src2     latched operands
//   is_mul/is_mulh op class (any multiply / high-half multiply)
//   is_rem         op returns the remainder
//   eff_word       W flag as it actually applies (ignored for MULH*)
//   a_mag, b_mag   operand magnitudes fed to the iterative datapath
//   neg_res        product/quotient must be negated at the end
//   neg_rem        remainder must be negated (dividend sign)
//   special        divide-by-zero, signed overflow or illegal op
//   special_val    unformatted result for the special cases
//   iter_n         iteration count (32 for W ops, 64 otherwise)
module ysyx_22050133_mdu_prep
  import ysyx_22050133_mdu_pkg::*;
(
  input  logic [4:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            is_mul,
  output logic            is_mulh,
  output logic            is_rem,
  output logic            eff_word,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic            neg_res,
  output logic            neg_rem,
  output logic            special,
  output logic [XLEN-1:0] special_val,
  output logic [6:0]      iter_n
);

  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sa;
  logic            sb;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;

  // MUL (low half) is sign-agnostic, so it runs unsigned; MULHSU only
  // treats src1 as signed.
  always_comb begin
    is_mulh  = (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    is_mul   = (op == ALU_MUL) || is_mulh;
    is_div   = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    is_rem   = (op == ALU_REM) || (op == ALU_REMU);
    eff_word = word & ~is_mulh;
    a_signed = (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
    b_signed = (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);

    a_ext = src1;
    b_ext = src2;
    if (eff_word) begin
      a_ext = a_signed ? {{32{src1[31]}}, src1[31:0]} : {32'b0, src1[31:0]};
      b_ext = b_signed ? {{32{src2[31]}}, src2[31:0]} : {32'b0, src2[31:0]};
    end

    sa      = a_signed & a_ext[XLEN-1];
    sb      = b_signed & b_ext[XLEN-1];
    a_mag   = sa ? -a_ext : a_ext;
    b_mag   = sb ? -b_ext : b_ext;
    neg_res = sa ^ sb;
    neg_rem = sa;

    // Overflow is checked on the extended dividend, so a W op compares
    // against the sign-extended 32-bit minimum.
    div_zero = is_div && (b_ext == '0);
    overflow = is_div && b_signed && (b_ext == '1) &&
               (a_ext == (eff_word ? {{32{1'b1}}, MIN_S32} : MIN_S64));
    special  = ~(is_mul | is_div) | div_zero | overflow;

    special_val = '0;
    if (div_zero) begin
      special_val = is_rem ? a_ext : DIV_ZERO_Q;
    end else if (overflow) begin
      special_val = is_rem ? '0 : a_ext;
    end

    iter_n = eff_word ? ITER_W : ITER_D;
  end

endmodule

// File: rtl/ysyx_22050133_mdu_ctrl.sv
// Iterative multiply/divide unit and sequencer for the RV64 EX stage.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    op handshake from EX (ready only in IDLE)
//   op, word, src1, src2 ALUop, W flag and forwarded operands
//   flush                kills the in-flight op
//   out_valid/out_ready  result handshake toward WB
//   result               registered, W-formatted result
//   busy                 pipeline stall request (combinational)
// Macro MDU_FAST_MUL_EN: single-cycle multiply in PREP instead of the
// shift-add loop; division is iterative in both builds.
module ysyx_22050133_mdu_ctrl
  import ysyx_22050133_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  mdu_state_e      state;
  mdu_state_e      next_state;
  logic [4:0]      op_q;
  logic            word_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [6:0]      cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic            accept;

  logic            is_mul;
  logic            is_mulh;
  logic            is_rem;
  logic            eff_word;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            neg_res;
  logic            neg_rem;
  logic            special;
  logic [XLEN-1:0] special_val;
  logic [6:0]      iter_n;

  logic [XLEN:0]   r_sh;
  logic            ge;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] div_val;
  logic [127:0]    prod_full;
  logic [127:0]    prod_signed;
  logic [XLEN-1:0] mul_val;
`ifndef MDU_FAST_MUL_EN
  logic [127:0]    acc;
  logic [127:0]    acc_next;
  logic [XLEN:0]   acc_sum;
`endif

  ysyx_22050133_mdu_prep u_prep (
    .op          (op_q),
    .word        (word_q),
    .src1        (src1_q),
    .src2        (src2_q),
    .is_mul      (is_mul),
    .is_mulh     (is_mulh),
    .is_rem      (is_rem),
    .eff_word    (eff_word),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .neg_res     (neg_res),
    .neg_rem     (neg_rem),
    .special     (special),
    .special_val (special_val),
    .iter_n      (iter_n)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready & ~flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and stall request; flush overrides every transition.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = in_valid;
        if (in_valid) next_state = S_PREP;
      end
      S_PREP: begin
        busy = 1'b1;
        if (special) begin
          next_state = S_DONE;
        end else if (is_mul) begin
`ifdef MDU_FAST_MUL_EN
          next_state = S_DONE;
`else
          next_state = S_MUL;
`endif
        end else begin
          next_state = S_DIV;
        end
      end
`ifndef MDU_FAST_MUL_EN
      S_MUL: begin
        busy = 1'b1;
        if (cnt == 7'd1) next_state = S_DONE;
      end
`endif
      S_DIV: begin
        busy = 1'b1;
        if (cnt == 7'd1) next_state = S_DONE;
      end
      S_DONE: begin
        busy = ~out_ready;
        if (out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (flush) begin
      next_state = S_IDLE;
      if (state == S_IDLE) busy = 1'b0;
    end
  end

  // One restoring-divide step and one shift-add step, plus the sign
  // fix-ups, all computed on the post-step values so the final step can
  // write the result register directly.
  always_comb begin
    r_sh     = {rem, quo[XLEN-1]};
    ge       = (r_sh >= {1'b0, b_mag});
    rem_next = ge ? (r_sh[XLEN-1:0] - b_mag) : r_sh[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], ge};
    div_val  = is_rem ? (neg_rem ? -rem_next : rem_next)
                      : (neg_res ? -quo_next : quo_next);
`ifdef MDU_FAST_MUL_EN
    prod_full = {64'b0, a_mag} * {64'b0, b_mag};
`else
    // Multiplier sits in the low half and is shifted out as product bits
    // are shifted in; after 32 steps the product is 32 bits too high.
    acc_sum   = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
    acc_next  = {acc_sum, acc[63:1]};
    prod_full = eff_word ? {32'b0, acc_next[127:32]} : acc_next;
`endif
    prod_signed = neg_res ? -prod_full : prod_full;
    mul_val     = is_mulh ? prod_signed[127:64] : prod_signed[63:0];
  end

  // Operand latch, iteration registers and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      word_q <= 1'b0;
      src1_q <= '0;
      src2_q <= '0;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      result <= '0;
`ifndef MDU_FAST_MUL_EN
      acc    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= op;
            word_q <= word;
            src1_q <= src1;
            src2_q <= src2;
          end
        end
        S_PREP: begin
          cnt <= iter_n;
          rem <= '0;
          // W dividends are pre-aligned to the top so every step consumes quo[63].
          quo <= eff_word ? {a_mag[31:0], 32'b0} : a_mag;
`ifndef MDU_FAST_MUL_EN
          acc <= {64'b0, b_mag};
`endif
          if (!flush) begin
            if (special) begin
              result <= fmt_result(special_val, eff_word);
            end
`ifdef MDU_FAST_MUL_EN
            else if (is_mul) begin
              result <= fmt_result(mul_val, eff_word);
            end
`endif
          end
        end
`ifndef MDU_FAST_MUL_EN
        S_MUL: begin
          acc <= acc_next;
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1 && !flush) result <= fmt_result(mul_val, eff_word);
        end
`endif
        S_DIV: begin
          quo <= quo_next;
          rem <= rem_next;
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1 && !flush) result <= fmt_result(div_val, eff_word);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_mdu_ctrl.sv
// Directed self-checking bench for ysyx_22050133_mdu_ctrl.
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
module tb_ysyx_22050133_mdu_ctrl;
  import ysyx_22050133_mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT64 = 2;
  localparam int MUL_LAT32 = 2;
`else
  localparam int MUL_LAT64 = 66;
  localparam int MUL_LAT32 = 34;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic        word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int checks;
  int failures;

  ysyx_22050133_mdu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one op (called 1 time unit after a rising edge, unit idle) and
  // waits, bounded, for out_valid; lat is the cycle index of the first
  // out_valid with the accept cycle as cycle 0.
  task automatic applyStimulus(input logic [4:0] o, input logic w, input logic [63:0] a,
                               input logic [63:0] b, output int lat, output logic [63:0] res);
    in_valid  = 1'b1;
    op        = o;
    word      = w;
    src1      = a;
    src2      = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  task automatic runOp(input string tag, input logic [4:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
    int          lat;
    logic [63:0] res;
    applyStimulus(o, w, a, b, lat, res);
    checkOutput(tag, res, exp_res);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [63:0] res;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = '0;
    word      = 1'b0;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy",      64'(busy),      64'd0);
    checkOutput("rst_result",    result,         64'd0);

    runOp("div_neg",    ALU_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    runOp("rem_neg",    ALU_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66);
    runOp("divu_zero",  ALU_DIVU,   1'b0, 64'd5, 64'd0, ONES, 2);
    runOp("remu_zero",  ALU_REMU,   1'b0, 64'd5, 64'd0, 64'd5, 2);
    runOp("div_ovf",    ALU_DIV,    1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 2);
    runOp("remw_ovf",   ALU_REM,    1'b1, 64'h0000_0000_8000_0000, ONES, 64'd0, 2);
    runOp("mulhu_max",  ALU_MULHU,  1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT64);
    runOp("mulhu_word", ALU_MULHU,  1'b1, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT64);
    runOp("mulw",       ALU_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT32);
    runOp("mul_neg",    ALU_MUL,    1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, MUL_LAT64);
    runOp("mulh_neg",   ALU_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, MUL_LAT64);
    runOp("mulh_pos",   ALU_MULH,   1'b0, ONES, ONES, 64'd0, MUL_LAT64);
    runOp("mulhsu",     ALU_MULHSU, 1'b0, ONES, 64'd2, ONES, MUL_LAT64);
    runOp("divw_trunc", ALU_DIV,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    runOp("divu",       ALU_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 66);
    runOp("remu",       ALU_REMU,   1'b0, 64'd17, 64'd5, 64'd2, 66);
    runOp("illegal",    5'd0,       1'b0, 64'd1, 64'd2, 64'd0, 2);

    // Flush in cycle 20 of a DIV.
    in_valid = 1'b1;
    op       = ALU_DIV;
    word     = 1'b0;
    src1     = 64'd1000;
    src2     = 64'd3;
    #1;
    checkOutput("idle_busy_comb", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("prep_in_ready", 64'(in_ready), 64'd0);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    checkOutput("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_in_ready",  64'(in_ready),  64'd1);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_busy",      64'(busy),      64'd0);
    runOp("after_flush", ALU_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);

    // Back-pressure in DONE.
    applyStimulus(ALU_REMU, 1'b0, 64'd100, 64'd7, lat, res);
    checkOutput("bp_result", res, 64'd2);
    checkOutput("bp_lat", 64'(lat), 64'd66);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_result", result, 64'd2);
      checkOutput("bp_hold_valid",  64'(out_valid), 64'd1);
      checkOutput("bp_hold_busy",   64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_in_ready",  64'(in_ready),  64'd1);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a divide discards it.
    in_valid = 1'b1;
    op       = ALU_DIV;
    src1     = 64'd50;
    src2     = 64'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_in_ready",  64'(in_ready),  64'd1);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_busy",      64'(busy),      64'd0);
    checkOutput("midrst_result",    result,         64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
